// File: rtl/crc_serial_frame_checker.sv
// crc_serial_frame_checker
// Bit-serial CRC checker with SOF/EOF frame delimiting. One CRC is accumulated
// per frame. The checker reports a one-cycle verdict carrying the final CRC,
// a match flag against the received CRC and the frame length. Sits between a
// serial line deframer and the packet-status logic.
module crc_serial_frame_checker #(
    parameter int unsigned CRC_W     = 32,
    parameter logic [31:0] POLY      = 32'h04C11DB7,
    parameter logic [31:0] INIT      = 32'hFFFFFFFF,
    parameter bit          LSB_FIRST = 1'b1,
    parameter logic [31:0] XOR_OUT   = 32'hFFFFFFFF,
    parameter int unsigned MAX_BITS  = 16384,
    localparam int unsigned CNT_W    = $clog2(MAX_BITS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_bit,
    input  logic             data_valid,
    input  logic             sof,
    input  logic             eof,
    input  logic [CRC_W-1:0] received_crc,
    output logic             busy,
    output logic             result_valid,
    output logic             crc_ok,
    output logic [CRC_W-1:0] crc_value,
    output logic [CNT_W-1:0] frame_bits,
    output logic             frame_abort,
    output logic             overflow
);

    function automatic logic [CRC_W-1:0] reverse_bits(input logic [CRC_W-1:0] v);
        logic [CRC_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < CRC_W; i++) begin
            r[i] = v[CRC_W-1-i];
        end
        return r;
    endfunction

    localparam logic [CRC_W-1:0] POLY_T   = POLY[CRC_W-1:0];
    localparam logic [CRC_W-1:0] POLY_REF = reverse_bits(POLY_T);
    localparam logic [CRC_W-1:0] INIT_T   = INIT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] XOR_T    = XOR_OUT[CRC_W-1:0];
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BITS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // One shift of the CRC register with one data bit.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] r, input logic b);
        logic [CRC_W-1:0] nxt;
        if (LSB_FIRST) begin
            nxt = (r >> 1) ^ ((r[0] ^ b) ? POLY_REF : '0);
        end else begin
            nxt = (r << 1) ^ ((r[CRC_W-1] ^ b) ? POLY_T : '0);
        end
        return nxt;
    endfunction

    // S_DEFER: a SOF+EOF bit that aborts an active frame is a complete 1-bit
    // frame; its verdict is pushed out one cycle so it never coincides with
    // the abort pulse.
    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_REPORT,
        S_DEFER
    } state_t;

    state_t           state;
    logic [CRC_W-1:0] crc_reg;
    logic [CRC_W-1:0] rx_crc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic             start;
    logic             cnt_full;
    logic [CRC_W-1:0] step_nxt;
    logic [CRC_W-1:0] fin_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ovf_nxt;
    logic             ok_nxt;
    logic [CRC_W-1:0] fin_held;
    logic             ok_held;

    // Next register, count and verdict for the bit currently presented.
    always_comb begin
        start    = data_valid & sof;
        cnt_full = (cnt == CNT_MAX);
        step_nxt = crc_step(start ? INIT_T : crc_reg, data_bit);
        cnt_nxt  = start ? CNT_ONE : (cnt_full ? cnt : cnt + CNT_ONE);
        ovf_nxt  = start ? 1'b0 : (ovf | cnt_full);
        fin_nxt  = step_nxt ^ XOR_T;
        ok_nxt   = (fin_nxt == received_crc) & ~ovf_nxt;
        fin_held = crc_reg ^ XOR_T;
        ok_held  = (fin_held == rx_crc) & ~ovf;
    end

    // Frame FSM with registered status and verdict outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            crc_reg      <= INIT_T;
            rx_crc       <= '0;
            cnt          <= '0;
            ovf          <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            crc_ok       <= 1'b0;
            crc_value    <= '0;
            frame_bits   <= '0;
            frame_abort  <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            frame_abort  <= 1'b0;
            case (state)
                S_IDLE, S_REPORT: begin
                    if (start) begin
                        crc_reg <= step_nxt;
                        cnt     <= cnt_nxt;
                        ovf     <= ovf_nxt;
                        if (eof) begin
                            rx_crc       <= received_crc;
                            result_valid <= 1'b1;
                            crc_value    <= fin_nxt;
                            crc_ok       <= ok_nxt;
                            frame_bits   <= cnt_nxt;
                            overflow     <= ovf_nxt;
                            state        <= S_REPORT;
                            busy         <= 1'b0;
                        end else begin
                            state <= S_ACTIVE;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_ACTIVE: begin
                    if (data_valid) begin
                        crc_reg <= step_nxt;
                        cnt     <= cnt_nxt;
                        ovf     <= ovf_nxt;
                        if (sof) begin
                            frame_abort <= 1'b1;
                            if (eof) begin
                                rx_crc <= received_crc;
                                state  <= S_DEFER;
                                busy   <= 1'b0;
                            end
                        end else if (eof) begin
                            rx_crc       <= received_crc;
                            result_valid <= 1'b1;
                            crc_value    <= fin_nxt;
                            crc_ok       <= ok_nxt;
                            frame_bits   <= cnt_nxt;
                            overflow     <= ovf_nxt;
                            state        <= S_REPORT;
                            busy         <= 1'b0;
                        end
                    end
                end
                S_DEFER: begin
                    result_valid <= 1'b1;
                    crc_value    <= fin_held;
                    crc_ok       <= ok_held;
                    frame_bits   <= cnt;
                    overflow     <= ovf;
                    state        <= S_REPORT;
                    busy         <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc_serial_frame_checker.sv
// Directed bench for crc_serial_frame_checker: CRC-32 default instance,
// CRC-16/CCITT MSB-first instance and a MAX_BITS=64 instance share the
// serial stimulus; each scenario checks the instance it targets.
module tb_crc_serial_frame_checker;

    logic        clk;
    logic        rst;
    logic        data_bit;
    logic        data_valid;
    logic        sof;
    logic        eof;
    logic [31:0] rc_a;
    logic [15:0] rc_b;
    logic [31:0] rc_c;

    logic        a_busy, a_rv, a_ok, a_abort, a_ovf;
    logic [31:0] a_val;
    logic [14:0] a_bits;
    logic        b_busy, b_rv, b_ok, b_abort, b_ovf;
    logic [15:0] b_val;
    logic [14:0] b_bits;
    logic        c_busy, c_rv, c_ok, c_abort, c_ovf;
    logic [31:0] c_val;
    logic [6:0]  c_bits;

    int n_checks = 0;
    int n_fail   = 0;
    int nv_a     = 0;
    int nab_a    = 0;
    int n_both   = 0;

    logic [71:0] msg_digits = "123456789";
    logic [71:0] msg_a      = {8'h61, 64'h0};

    crc_serial_frame_checker u_a (
        .clk(clk), .rst(rst), .data_bit(data_bit), .data_valid(data_valid),
        .sof(sof), .eof(eof), .received_crc(rc_a), .busy(a_busy),
        .result_valid(a_rv), .crc_ok(a_ok), .crc_value(a_val),
        .frame_bits(a_bits), .frame_abort(a_abort), .overflow(a_ovf)
    );

    crc_serial_frame_checker #(
        .CRC_W(16), .POLY(32'h0000_1021), .INIT(32'h0000_FFFF),
        .LSB_FIRST(1'b0), .XOR_OUT(32'h0000_0000)
    ) u_b (
        .clk(clk), .rst(rst), .data_bit(data_bit), .data_valid(data_valid),
        .sof(sof), .eof(eof), .received_crc(rc_b), .busy(b_busy),
        .result_valid(b_rv), .crc_ok(b_ok), .crc_value(b_val),
        .frame_bits(b_bits), .frame_abort(b_abort), .overflow(b_ovf)
    );

    crc_serial_frame_checker #(
        .MAX_BITS(64)
    ) u_c (
        .clk(clk), .rst(rst), .data_bit(data_bit), .data_valid(data_valid),
        .sof(sof), .eof(eof), .received_crc(rc_c), .busy(c_busy),
        .result_valid(c_rv), .crc_ok(c_ok), .crc_value(c_val),
        .frame_bits(c_bits), .frame_abort(c_abort), .overflow(c_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count verdicts/aborts of the default instance and any overlap of strobes.
    always @(negedge clk) begin
        if (a_rv === 1'b1) nv_a++;
        if (a_abort === 1'b1) nab_a++;
        if ((a_rv & a_abort) | (b_rv & b_abort) | (c_rv & c_abort)) n_both++;
    end

    function automatic logic msg_bit(input logic [71:0] m, input int k, input bit msb_first);
        logic [7:0] by;
        by = m[71-8*(k/8) -: 8];
        return msb_first ? by[7-(k%8)] : by[k%8];
    endfunction

    task automatic set_in(input logic v, input logic b, input logic s, input logic e);
        data_valid = v;
        data_bit   = b;
        sof        = s;
        eof        = e;
    endtask

    task automatic drive(input logic v, input logic b, input logic s, input logic e);
        @(negedge clk);
        set_in(v, b, s, e);
    endtask

    // Bits first..last-1 of m; optional idle cycle (with stray sof/eof) every gap bits.
    task automatic send_bits(input logic [71:0] m, input int first, input int last,
                             input bit msb_first, input bit with_sof, input bit with_eof,
                             input int gap);
        for (int k = first; k < last; k++) begin
            if (gap > 0 && k > first && (k - first) % gap == 0)
                drive(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
            drive(1'b1, msg_bit(m, k, msb_first), with_sof && k == first,
                  with_eof && k == last - 1);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        rc_a = '0; rc_b = '0; rc_c = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: actual %b required 0", a_busy); end
        n_checks++; if (a_rv !== 1'b0) begin n_fail++; $display("FAIL reset_rv: actual %b required 0", a_rv); end
        n_checks++; if (a_ok !== 1'b0) begin n_fail++; $display("FAIL reset_ok: actual %b required 0", a_ok); end
        n_checks++; if (a_val !== 32'h0) begin n_fail++; $display("FAIL reset_val: actual %h required 0", a_val); end
        n_checks++; if (a_bits !== 15'd0) begin n_fail++; $display("FAIL reset_bits: actual %0d required 0", a_bits); end
        n_checks++; if (a_abort !== 1'b0) begin n_fail++; $display("FAIL reset_abort: actual %b required 0", a_abort); end
        n_checks++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: actual %b required 0", a_ovf); end
        n_checks++; if (b_val !== 16'h0) begin n_fail++; $display("FAIL reset_b_val: actual %h required 0", b_val); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_crc32_good;
        rc_a = 32'hCBF43926;
        send_bits(msg_digits, 0, 71, 1'b0, 1'b1, 1'b0, 0);
        @(negedge clk);
        n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL good_busy_mid: actual %b required 1", a_busy); end
        n_checks++; if (a_rv !== 1'b0) begin n_fail++; $display("FAIL good_rv_mid: actual %b required 0", a_rv); end
        set_in(1'b1, msg_bit(msg_digits, 71, 1'b0), 1'b0, 1'b1);
        @(negedge clk);
        n_checks++; if (a_rv !== 1'b1) begin n_fail++; $display("FAIL good_rv: actual %b required 1", a_rv); end
        n_checks++; if (a_ok !== 1'b1) begin n_fail++; $display("FAIL good_ok: actual %b required 1", a_ok); end
        n_checks++; if (a_val !== 32'hCBF43926) begin n_fail++; $display("FAIL good_val: actual %h required cbf43926", a_val); end
        n_checks++; if (a_bits !== 15'd72) begin n_fail++; $display("FAIL good_bits: actual %0d required 72", a_bits); end
        n_checks++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL good_ovf: actual %b required 0", a_ovf); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL good_busy_report: actual %b required 0", a_busy); end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++; if (a_rv !== 1'b0) begin n_fail++; $display("FAIL good_rv_pulse: actual %b required 0", a_rv); end
        n_checks++; if (a_ok !== 1'b1) begin n_fail++; $display("FAIL good_ok_held: actual %b required 1", a_ok); end
        n_checks++; if (a_val !== 32'hCBF43926) begin n_fail++; $display("FAIL good_val_held: actual %h required cbf43926", a_val); end
    endtask

    task automatic test_crc32_bad;
        rc_a = 32'hCBF43927;
        send_bits(msg_digits, 0, 72, 1'b0, 1'b1, 1'b1, 0);
        @(negedge clk);
        n_checks++; if (a_rv !== 1'b1) begin n_fail++; $display("FAIL bad_rv: actual %b required 1", a_rv); end
        n_checks++; if (a_ok !== 1'b0) begin n_fail++; $display("FAIL bad_ok: actual %b required 0", a_ok); end
        n_checks++; if (a_val !== 32'hCBF43926) begin n_fail++; $display("FAIL bad_val: actual %h required cbf43926", a_val); end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_crc16_msb_first;
        rc_b = 16'h29B1;
        send_bits(msg_digits, 0, 72, 1'b1, 1'b1, 1'b1, 0);
        @(negedge clk);
        n_checks++; if (b_rv !== 1'b1) begin n_fail++; $display("FAIL crc16_rv: actual %b required 1", b_rv); end
        n_checks++; if (b_ok !== 1'b1) begin n_fail++; $display("FAIL crc16_ok: actual %b required 1", b_ok); end
        n_checks++; if (b_val !== 16'h29B1) begin n_fail++; $display("FAIL crc16_val: actual %h required 29b1", b_val); end
        n_checks++; if (b_bits !== 15'd72) begin n_fail++; $display("FAIL crc16_bits: actual %0d required 72", b_bits); end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_abort;
        int v0;
        int ab0;
        rc_a = 32'hCBF43926;
        v0  = nv_a;
        ab0 = nab_a;
        send_bits(msg_digits, 0, 40, 1'b0, 1'b1, 1'b0, 0);
        drive(1'b1, msg_bit(msg_digits, 0, 1'b0), 1'b1, 1'b0);
        @(negedge clk);
        n_checks++; if (a_abort !== 1'b1) begin n_fail++; $display("FAIL abort_pulse: actual %b required 1", a_abort); end
        n_checks++; if (a_rv !== 1'b0) begin n_fail++; $display("FAIL abort_rv: actual %b required 0", a_rv); end
        n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy: actual %b required 1", a_busy); end
        set_in(1'b1, msg_bit(msg_digits, 1, 1'b0), 1'b0, 1'b0);
        @(negedge clk);
        n_checks++; if (a_abort !== 1'b0) begin n_fail++; $display("FAIL abort_one_cycle: actual %b required 0", a_abort); end
        set_in(1'b1, msg_bit(msg_digits, 2, 1'b0), 1'b0, 1'b0);
        send_bits(msg_digits, 3, 72, 1'b0, 1'b0, 1'b1, 0);
        @(negedge clk);
        n_checks++; if (a_rv !== 1'b1) begin n_fail++; $display("FAIL abort_rv_new: actual %b required 1", a_rv); end
        n_checks++; if (a_ok !== 1'b1) begin n_fail++; $display("FAIL abort_ok_new: actual %b required 1", a_ok); end
        n_checks++; if (a_bits !== 15'd72) begin n_fail++; $display("FAIL abort_bits_new: actual %0d required 72", a_bits); end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        n_checks++; if (nv_a - v0 !== 1) begin n_fail++; $display("FAIL abort_verdicts: actual %0d required 1", nv_a - v0); end
        n_checks++; if (nab_a - ab0 !== 1) begin n_fail++; $display("FAIL abort_count: actual %0d required 1", nab_a - ab0); end
    endtask

    task automatic test_overflow_back_to_back;
        rc_c = 32'hCBF43926;
        send_bits(msg_digits, 0, 72, 1'b0, 1'b1, 1'b1, 0);
        @(negedge clk);
        n_checks++; if (c_rv !== 1'b1) begin n_fail++; $display("FAIL ovf_rv: actual %b required 1", c_rv); end
        n_checks++; if (c_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: actual %b required 1", c_ovf); end
        n_checks++; if (c_ok !== 1'b0) begin n_fail++; $display("FAIL ovf_ok: actual %b required 0", c_ok); end
        n_checks++; if (c_bits !== 7'd64) begin n_fail++; $display("FAIL ovf_bits: actual %0d required 64", c_bits); end
        n_checks++; if (c_val !== 32'hCBF43926) begin n_fail++; $display("FAIL ovf_val: actual %h required cbf43926", c_val); end
        rc_c = 32'hE8B7BE43;
        set_in(1'b1, msg_bit(msg_a, 0, 1'b0), 1'b1, 1'b0);
        @(negedge clk);
        n_checks++; if (c_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: actual %b required 1", c_busy); end
        n_checks++; if (c_rv !== 1'b0) begin n_fail++; $display("FAIL b2b_rv_mid: actual %b required 0", c_rv); end
        set_in(1'b1, msg_bit(msg_a, 1, 1'b0), 1'b0, 1'b0);
        send_bits(msg_a, 2, 8, 1'b0, 1'b0, 1'b1, 0);
        @(negedge clk);
        n_checks++; if (c_rv !== 1'b1) begin n_fail++; $display("FAIL b2b_rv: actual %b required 1", c_rv); end
        n_checks++; if (c_ok !== 1'b1) begin n_fail++; $display("FAIL b2b_ok: actual %b required 1", c_ok); end
        n_checks++; if (c_val !== 32'hE8B7BE43) begin n_fail++; $display("FAIL b2b_val: actual %h required e8b7be43", c_val); end
        n_checks++; if (c_bits !== 7'd8) begin n_fail++; $display("FAIL b2b_bits: actual %0d required 8", c_bits); end
        n_checks++; if (c_ovf !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf: actual %b required 0", c_ovf); end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_reset_stray_gaps;
        int v0;
        int ab0;
        rc_a = 32'hCBF43926;
        v0  = nv_a;
        ab0 = nab_a;
        send_bits(msg_digits, 0, 30, 1'b0, 1'b1, 1'b0, 0);
        @(negedge clk);
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: actual %b required 0", a_busy); end
        n_checks++; if (a_val !== 32'h0) begin n_fail++; $display("FAIL rst_mid_val: actual %h required 0", a_val); end
        send_bits(msg_digits, 0, 16, 1'b0, 1'b0, 1'b1, 0);
        @(negedge clk);
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL stray_busy: actual %b required 0", a_busy); end
        n_checks++; if (a_rv !== 1'b0) begin n_fail++; $display("FAIL stray_rv: actual %b required 0", a_rv); end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        send_bits(msg_digits, 0, 72, 1'b0, 1'b1, 1'b1, 5);
        @(negedge clk);
        n_checks++; if (a_rv !== 1'b1) begin n_fail++; $display("FAIL gap_rv: actual %b required 1", a_rv); end
        n_checks++; if (a_ok !== 1'b1) begin n_fail++; $display("FAIL gap_ok: actual %b required 1", a_ok); end
        n_checks++; if (a_val !== 32'hCBF43926) begin n_fail++; $display("FAIL gap_val: actual %h required cbf43926", a_val); end
        n_checks++; if (a_bits !== 15'd72) begin n_fail++; $display("FAIL gap_bits: actual %0d required 72", a_bits); end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        n_checks++; if (nv_a - v0 !== 1) begin n_fail++; $display("FAIL rst_gap_verdicts: actual %0d required 1", nv_a - v0); end
        n_checks++; if (nab_a !== ab0) begin n_fail++; $display("FAIL rst_gap_aborts: actual %0d required %0d", nab_a, ab0); end
    endtask

    initial begin
        test_reset;
        test_crc32_good;
        test_crc32_bad;
        test_crc16_msb_first;
        test_abort;
        test_overflow_back_to_back;
        test_reset_stray_gaps;
        n_checks++; if (n_both !== 0) begin n_fail++; $display("FAIL strobe_overlap: actual %0d required 0", n_both); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
